// File: rtl/adxl355_drdy_pkg.sv
// Shared definitions for the multi-channel ADXL355 sync/DRDY generator:
// microsecond-to-cycle conversion, the elaboration range check, the default
// system clock rate and the per-channel state encoding.
package adxl355_drdy_pkg;

  localparam longint unsigned DEFAULT_CLK_HZ = 64'd40000000;

  // Channel delay counter is either idle or counting down to its DRDY pulse.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } chan_state_e;

  // Whole cycles in 'us' microseconds; multiply before dividing so that
  // sub-microsecond clock periods do not truncate to zero.
  function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                   input longint unsigned hz);
    return (us * hz) / 64'd1000000;
  endfunction

  // True when 'value' is representable in an unsigned counter of 'bits' bits.
  function automatic bit fits_in_bits(input longint unsigned value,
                                      input int unsigned     bits);
    if (bits >= 32'd64) begin
      return 1'b1;
    end else begin
      return value < (64'd1 << bits);
    end
  endfunction

endpackage

// File: rtl/adxl355_drdy_chan.sv
// One DRDY channel: shadow delay register, delay counter, single-cycle DRDY
// pulse and sticky overrun flag. The shadow value is only consumed on sync,
// so a run-time delay update always lands on a period boundary.
module adxl355_drdy_chan
  import adxl355_drdy_pkg::*;
#(
  parameter int unsigned             timing_bits = 20,
  parameter logic [timing_bits-1:0]  reset_delay = {timing_bits{1'b0}}
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_sync,
  input  logic                   i_enable,
  input  logic [timing_bits-1:0] i_delay,
  input  logic                   i_delay_load,
  input  logic                   i_overrun_clr,
  output logic                   o_drdy,
  output logic                   o_busy,
  output logic                   o_overrun
);

  localparam logic [timing_bits-1:0] ZERO = {timing_bits{1'b0}};
  localparam logic [timing_bits-1:0] ONE  = {{(timing_bits-1){1'b0}}, 1'b1};

  logic [timing_bits-1:0] shadow_q, shadow_d;
  logic [timing_bits-1:0] cnt_q, cnt_d;
  chan_state_e            state_q, state_d;
  logic                   drdy_q, drdy_d;
  logic                   ovr_q, ovr_d;
  logic                   ovr_set_s;

  // Next-state logic: shadow load, period start/abort on sync, countdown.
  // The counter holds the cycles remaining before the pulse cycle, so a delay
  // of D keeps the channel busy for D-1 cycles and pulses in cycle D.
  always_comb begin
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    drdy_d    = 1'b0;
    ovr_set_s = 1'b0;
    if (i_delay_load) begin
      shadow_d = i_delay;
    end else begin
      shadow_d = shadow_q;
    end
    if (i_sync) begin
      // A sync that finds the channel still counting aborts that period.
      ovr_set_s = (state_q == CH_BUSY);
      if (!i_enable || (shadow_q == ZERO)) begin
        state_d = CH_IDLE;
        cnt_d   = ZERO;
      end else if (shadow_q == ONE) begin
        state_d = CH_IDLE;
        cnt_d   = ZERO;
        drdy_d  = 1'b1;
      end else begin
        state_d = CH_BUSY;
        cnt_d   = shadow_q - ONE;
      end
    end else if (state_q == CH_BUSY) begin
      if (cnt_q == ONE) begin
        state_d = CH_IDLE;
        cnt_d   = ZERO;
        drdy_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
    // Setting wins over clearing so a same-cycle overrun is never lost.
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (i_overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Channel state registers; the shadow comes out of reset at the default delay.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_q <= reset_delay;
      cnt_q    <= ZERO;
      state_q  <= CH_IDLE;
      drdy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      drdy_q   <= drdy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign o_drdy    = drdy_q;
  assign o_busy    = (state_q == CH_BUSY);
  assign o_overrun = ovr_q;

endmodule

// File: rtl/adxl355_drdy_multi.sv
// Multi-channel ADXL355 sync/DRDY generator. Stretches the 1 kHz single-cycle
// sync into the accelerometer hardware sync and drives one delayed DRDY pulse
// per channel. Optional missing-sync watchdog enabled by defining
// ADXL355_DRDY_WATCHDOG_EN; otherwise o_sync_lost is tied low.
module adxl355_drdy_multi
  import adxl355_drdy_pkg::*;
#(
  parameter longint unsigned clk_out0_hz   = DEFAULT_CLK_HZ,
  parameter int unsigned     channels      = 2,
  parameter int unsigned     timing_bits   = 20,
  parameter int unsigned     sync_width_us = 20,
  parameter int unsigned     drdy_delay_us = 50,
  parameter int unsigned     watchdog_us   = 1500
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_clk_sync,
  input  logic [channels-1:0]             i_enable,
  input  logic [channels*timing_bits-1:0] i_delay,
  input  logic                            i_delay_load,
  input  logic                            i_overrun_clr,
  output logic                            o_clk_sync,
  output logic [channels-1:0]             o_clk_drdy,
  output logic [channels-1:0]             o_busy,
  output logic [channels-1:0]             o_overrun,
  output logic                            o_sync_lost
);

  localparam longint unsigned W_CYC  = us_to_cycles(64'(sync_width_us), clk_out0_hz);
  localparam longint unsigned D0_CYC = us_to_cycles(64'(drdy_delay_us), clk_out0_hz);
  localparam logic [timing_bits-1:0] W_VAL  = W_CYC[timing_bits-1:0];
  localparam logic [timing_bits-1:0] D0_VAL = D0_CYC[timing_bits-1:0];
  localparam logic [timing_bits-1:0] ZERO   = {timing_bits{1'b0}};
  localparam logic [timing_bits-1:0] ONE    = {{(timing_bits-1){1'b0}}, 1'b1};

  if ((channels < 32'd1) || (channels > 32'd8)) begin : g_bad_channels
    $error("adxl355_drdy_multi: channels must be 1..8");
  end
  if (!fits_in_bits(W_CYC, timing_bits) || !fits_in_bits(D0_CYC, timing_bits)) begin : g_bad_timing
    $error("adxl355_drdy_multi: sync width or DRDY delay does not fit timing_bits");
  end

  // ---------------------------------------------------------------- stretcher
  logic [timing_bits-1:0] width_cnt_q, width_cnt_d;
  logic                   sync_out_q, sync_out_d;

  // Reload on every sync (no gap for back-to-back syncs), else count down.
  always_comb begin
    width_cnt_d = width_cnt_q;
    if (i_clk_sync) begin
      width_cnt_d = W_VAL;
    end else if (width_cnt_q != ZERO) begin
      width_cnt_d = width_cnt_q - ONE;
    end else begin
      width_cnt_d = width_cnt_q;
    end
    sync_out_d = (width_cnt_d != ZERO);
  end

  // Width counter and the registered stretched sync.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      width_cnt_q <= ZERO;
      sync_out_q  <= 1'b0;
    end else begin
      width_cnt_q <= width_cnt_d;
      sync_out_q  <= sync_out_d;
    end
  end

  assign o_clk_sync = sync_out_q;

  // ----------------------------------------------------------------- channels
  for (genvar k = 0; k < channels; k++) begin : g_chan
    adxl355_drdy_chan #(
      .timing_bits (timing_bits),
      .reset_delay (D0_VAL)
    ) u_chan (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_sync        (i_clk_sync),
      .i_enable      (i_enable[k]),
      .i_delay       (i_delay[k*timing_bits +: timing_bits]),
      .i_delay_load  (i_delay_load),
      .i_overrun_clr (i_overrun_clr),
      .o_drdy        (o_clk_drdy[k]),
      .o_busy        (o_busy[k]),
      .o_overrun     (o_overrun[k])
    );
  end

  // ----------------------------------------------------------------- watchdog
`ifdef ADXL355_DRDY_WATCHDOG_EN
  localparam longint unsigned G_CYC = us_to_cycles(64'(watchdog_us), clk_out0_hz);
  localparam logic [timing_bits-1:0] G_VAL = G_CYC[timing_bits-1:0];

  if (!fits_in_bits(G_CYC, timing_bits)) begin : g_bad_watchdog
    $error("adxl355_drdy_multi: watchdog period does not fit timing_bits");
  end

  logic [timing_bits-1:0] wd_cnt_q, wd_cnt_d;
  logic                   lost_q, lost_d;

  // Cycles since the last sync, saturating at the watchdog limit. The cycle
  // after a sync counts as one, so the flag rises G cycles after that sync.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (i_clk_sync) begin
      wd_cnt_d = ONE;
    end else if (wd_cnt_q < G_VAL) begin
      wd_cnt_d = wd_cnt_q + ONE;
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
    lost_d = (wd_cnt_d >= G_VAL);
  end

  // Watchdog counter and registered sync-lost flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wd_cnt_q <= ZERO;
      lost_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      lost_q   <= lost_d;
    end
  end

  assign o_sync_lost = lost_q;
`else
  assign o_sync_lost = 1'b0;
`endif

endmodule
